// File: rtl/pc_pkg.sv
// Shared types and constants for the PC fetch unit: redirect selector,
// fetch FSM states and the instruction width.
package pc_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    RS_NONE   = 2'b00,
    RS_BRANCH = 2'b01,
    RS_JUMP   = 2'b10,
    RS_REG    = 2'b11
  } redirect_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational redirect target calculator with alignment handling.
// Build option PC_MISALIGN_TRAP_EN: misaligned targets divert to TRAP_VEC.
module pc_target_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h80)
) (
  input  logic [1:0]        redirect_sel,
  input  logic [ADDR_W-1:0] redirect_pc4,
  input  logic [ADDR_W-1:0] sign_imm,
  input  logic [25:0]       jump_idx,
  input  logic [ADDR_W-1:0] reg_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              misalign_hit
);

  // Jump keeps the upper PC bits above bit 27; narrow PCs keep none.
  localparam int                JLOW_W    = (ADDR_W < 28) ? ADDR_W : 28;
  localparam logic [ADDR_W-1:0] JLOW_MASK = {ADDR_W{1'b1}} >> (ADDR_W - JLOW_W);

  redirect_sel_e     sel_s;
  logic [27:0]       jfield_s;
  logic [ADDR_W-1:0] raw_s;

  assign sel_s    = redirect_sel_e'(redirect_sel);
  assign jfield_s = {jump_idx, 2'b00};

  // Raw (unaligned) target selection.
  always_comb begin
    raw_s    = '0;
    redirect = 1'b0;
    case (sel_s)
      RS_BRANCH: begin
        raw_s    = redirect_pc4 + (sign_imm << 2'd2);
        redirect = 1'b1;
      end
      RS_JUMP: begin
        raw_s    = (redirect_pc4 & ~JLOW_MASK) | (ADDR_W'(jfield_s) & JLOW_MASK);
        redirect = 1'b1;
      end
      RS_REG: begin
        raw_s    = reg_target;
        redirect = 1'b1;
      end
      default: begin
        raw_s    = '0;
        redirect = 1'b0;
      end
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned redirect targets divert to the trap vector.
  always_comb begin
    if (redirect && (raw_s[1:0] != 2'b00)) begin
      target       = TRAP_VEC;
      misalign_hit = 1'b1;
    end else begin
      target       = raw_s;
      misalign_hit = 1'b0;
    end
  end
`else
  logic [ADDR_W-1:0] unused_trap_s;

  assign unused_trap_s = TRAP_VEC;
  assign target        = raw_s & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign misalign_hit  = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC sequencing, redirect handling, single-entry output slot.
// Build option PC_MISALIGN_TRAP_EN (handled in pc_target_gen) enables misalign trapping.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h80)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         redirect_sel,
  input  logic [ADDR_W-1:0]  redirect_pc4,
  input  logic [ADDR_W-1:0]  sign_imm,
  input  logic [25:0]        jump_idx,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc4,
  output logic               misalign
);

  fetch_state_e       state_r, state_s;
  logic [ADDR_W-1:0]  pc_r, pc_plus4_s, target_s;
  logic               redirect_s, misalign_hit_s;
  logic               req_s, take_s, consume_s;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  instr_pc_r, instr_pc4_r;
  logic               instr_valid_r, misalign_r;

  pc_target_gen #(
    .ADDR_W   (ADDR_W),
    .TRAP_VEC (TRAP_VEC)
  ) u_target_gen (
    .redirect_sel (redirect_sel),
    .redirect_pc4 (redirect_pc4),
    .sign_imm     (sign_imm),
    .jump_idx     (jump_idx),
    .reg_target   (reg_target),
    .redirect     (redirect_s),
    .target       (target_s),
    .misalign_hit (misalign_hit_s)
  );

  assign pc_plus4_s = pc_r + ADDR_W'(32'd4);

  // Handshake decode: request only when the slot can take the returned word.
  always_comb begin
    consume_s = instr_valid_r & ~stall;
    if (!reset && (state_r == FETCH)) begin
      req_s = ~instr_valid_r | ~stall;
    end else begin
      req_s = 1'b0;
    end
    take_s = req_s & imem_ack & ~redirect_s;
  end

  // Next-state logic; an unacknowledged request abandoned by a redirect is drained.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
      end
      FETCH: begin
        if (redirect_s && req_s && !imem_ack) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Program counter: redirect wins over sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_VEC;
    end else if (redirect_s) begin
      pc_r <= target_s;
    end else if (take_s) begin
      pc_r <= pc_plus4_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Output slot: refill on accepted data, flush on redirect, clear on consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_r <= 1'b0;
      instr_r       <= '0;
      instr_pc_r    <= '0;
      instr_pc4_r   <= '0;
    end else if (redirect_s) begin
      instr_valid_r <= 1'b0;
    end else if (take_s) begin
      instr_valid_r <= 1'b1;
      instr_r       <= imem_rdata;
      instr_pc_r    <= pc_r;
      instr_pc4_r   <= pc_plus4_s;
    end else if (consume_s) begin
      instr_valid_r <= 1'b0;
    end else begin
      instr_valid_r <= instr_valid_r;
    end
  end

  // One-cycle misalign pulse accompanying a trapped redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= redirect_s & misalign_hit_s;
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_pc4   = instr_pc4_r;
  assign misalign    = misalign_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// stall/redirect traffic checked against an instruction-stream model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;
  import pc_pkg::*;

  localparam logic [31:0] TB_TRAP = 32'h80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_pc4, sign_imm, reg_target;
  logic [25:0] jump_idx;
  logic        imem_req, imem_ack, instr_valid, misalign;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, instr_pc4;

  logic [1:0]  r8_sel;
  logic [7:0]  r8_tgt, addr8, ipc8, ipc48;
  logic        req8, valid8, mis8;
  logic [31:0] instr8;

  int          lat_mode;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic        ovr_ack;
  logic [31:0] ovr_data;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  // Architectural target: plain arithmetic on the redirect fields.
  function automatic logic [31:0] model_target(input logic [1:0] sel, input logic [31:0] pc4,
                                               input logic [31:0] imm, input logic [25:0] jidx,
                                               input logic [31:0] rt);
    logic [31:0] t;
    case (sel)
      2'd1:    t = pc4 + imm * 32'd4;
      2'd2:    t = {pc4[31:28], 28'd0} + {4'd0, jidx, 2'd0};
      default: t = rt;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    if (t % 32'd4 != 32'd0) t = TB_TRAP;
`else
    t = t - (t % 32'd4);
`endif
    return t;
  endfunction

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_sel(redirect_sel),
    .redirect_pc4(redirect_pc4), .sign_imm(sign_imm), .jump_idx(jump_idx),
    .reg_target(reg_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4), .misalign(misalign)
  );

  pc_fetch_unit #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect_sel(r8_sel),
    .redirect_pc4(8'h00), .sign_imm(8'h00), .jump_idx(26'h0),
    .reg_target(r8_tgt), .imem_req(req8), .imem_addr(addr8),
    .imem_ack(req8), .imem_rdata(32'h0), .instr_valid(valid8),
    .instr(instr8), .instr_pc(ipc8), .instr_pc4(ipc48), .misalign(mis8)
  );

  // Memory: zero-wait (ack with request) or fixed latency after the request is seen.
  always @(posedge clk) begin
    if (reset || lat_mode == 0) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end else if (imem_req) begin
      pend  <= 1'b1;
      cnt   <= lat_mode - 1;
      paddr <= imem_addr;
    end
  end

  always_comb begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if (ovr_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = ovr_data;
    end else if (lat_mode == 0) begin
      imem_ack   = imem_req;
      imem_rdata = memf(imem_addr);
    end else begin
      imem_ack   = pend && (cnt == 0);
      imem_rdata = memf(paddr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_sel = 2'd0; ovr_ack = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    lat_mode = 0; stall = 1'b0; redirect_sel = 2'd0; r8_sel = 2'd0;
    ovr_ack = 1'b1; ovr_data = 32'hDEAD_BEEF;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        instr_pc4 !== 32'h0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got req=%0b v=%0b instr=%h pc=%h pc4=%h mis=%0b exp all zero",
               imem_req, instr_valid, instr, instr_pc, instr_pc4, misalign);
    end
    tick();
    ovr_ack = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== memf(32'h0) || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_stale_ack got v=%0b instr=%h pc=%h exp v=1 instr=%h pc=0",
               instr_valid, instr, instr_pc, memf(32'h0));
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_a = 32'(k) * 32'd4;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_a) begin
        errors++;
        $display("FAIL seq_addr k=%0d got req=%0b addr=%h exp %h", k, imem_req, imem_addr, exp_a);
      end
      if (k > 0) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_a - 32'd4 || instr_pc4 !== exp_a ||
            instr !== memf(exp_a - 32'd4)) begin
          errors++;
          $display("FAIL seq_out k=%0d got v=%0b pc=%h pc4=%h instr=%h exp pc=%h", k,
                   instr_valid, instr_pc, instr_pc4, instr, exp_a - 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_pc, h_pc4, h_i;
    stall = 1'b1;
    #1;
    h_pc = instr_pc; h_pc4 = instr_pc4; h_i = instr;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_entry got v=%0b req=%0b exp v=1 req=0", instr_valid, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== h_pc || instr_pc4 !== h_pc4 || instr !== h_i ||
          imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold i=%0d got v=%0b pc=%h instr=%h req=%0b exp pc=%h instr=%h req=0",
                 i, instr_valid, instr_pc, instr, imem_req, h_pc, h_i);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== h_pc + 32'd4) begin
      errors++;
      $display("FAIL stall_resume got req=%0b addr=%h exp %h", imem_req, imem_addr, h_pc + 32'd4);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== h_pc + 32'd4) begin
      errors++;
      $display("FAIL stall_next got v=%0b pc=%h exp %h", instr_valid, instr_pc, h_pc + 32'd4);
    end
  endtask

  task automatic test_branch();
    redirect_sel = 2'd1; redirect_pc4 = 32'h10; sign_imm = 32'hFFFF_FFFE;
    #1;
    tick();
    redirect_sel = 2'd0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h08) begin
      errors++;
      $display("FAIL branch_target got v=%0b req=%0b addr=%h exp v=0 addr=08",
               instr_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h08) begin
      errors++;
      $display("FAIL branch_refill got v=%0b pc=%h exp v=1 pc=08", instr_valid, instr_pc);
    end
  endtask

  task automatic test_jump();
    logic [31:0] exp_t;
    redirect_sel = 2'd2; redirect_pc4 = 32'h3000_0010; jump_idx = 26'h123;
    exp_t = model_target(2'd2, 32'h3000_0010, 32'h0, 26'h123, 32'h0);
    #1;
    tick();
    redirect_sel = 2'd0;
    #1;
    checks++;
    if (imem_addr !== exp_t || exp_t !== 32'h3000_048C) begin
      errors++;
      $display("FAIL jump_target got %h exp 3000048c", imem_addr);
    end
  endtask

  task automatic test_drain();
    int  n;
    logic bad;
    lat_mode = 3;
    do_reset();
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || imem_ack !== 1'b0) begin
      errors++;
      $display("FAIL drain_req got req=%0b addr=%h ack=%0b exp req=1 addr=0 ack=0",
               imem_req, imem_addr, imem_ack);
    end
    tick();
    redirect_sel = 2'd3; reg_target = 32'h40;
    #1;
    tick();
    redirect_sel = 2'd0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL drain_quiet got req=%0b exp 0", imem_req);
    end
    n = 0; bad = 1'b0;
    while (!imem_req && n < 12) begin
      if (instr_valid) bad = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n >= 12 || imem_addr !== 32'h40 || bad !== 1'b0) begin
      errors++;
      $display("FAIL drain_resume got cycles=%0d addr=%h stale_valid=%0b exp addr=40 stale_valid=0",
               n, imem_addr, bad);
    end
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== memf(32'h40)) begin
      errors++;
      $display("FAIL drain_data got v=%0b pc=%h instr=%h exp pc=40 instr=%h",
               instr_valid, instr_pc, instr, memf(32'h40));
    end
    lat_mode = 0;
    do_reset();
  endtask

  task automatic test_misalign();
    logic [31:0] exp_t;
    logic        exp_m;
    tick();
    redirect_sel = 2'd3; reg_target = 32'h22;
    exp_t = model_target(2'd3, 32'h0, 32'h0, 26'h0, 32'h22);
`ifdef PC_MISALIGN_TRAP_EN
    exp_m = 1'b1;
`else
    exp_m = 1'b0;
`endif
    #1;
    tick();
    redirect_sel = 2'd0;
    #1;
    checks++;
    if (imem_addr !== exp_t || misalign !== exp_m) begin
      errors++;
      $display("FAIL misalign_redirect got addr=%h mis=%0b exp addr=%h mis=%0b",
               imem_addr, misalign, exp_t, exp_m);
    end
    tick();
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse got %0b exp 0", misalign);
    end
  endtask

  task automatic test_wrap();
    r8_sel = 2'd3; r8_tgt = 8'hFC;
    #1;
    tick();
    r8_sel = 2'd0;
    #1;
    checks++;
    if (req8 !== 1'b1 || addr8 !== 8'hFC) begin
      errors++;
      $display("FAIL wrap_fc got req=%0b addr=%h exp fc", req8, addr8);
    end
    tick();
    checks++;
    if (addr8 !== 8'h00 || ipc8 !== 8'hFC || ipc48 !== 8'h00 || valid8 !== 1'b1 ||
        mis8 !== 1'b0 || instr8 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero got addr=%h pc=%h pc4=%h v=%0b exp addr=00 pc=fc pc4=00 v=1",
               addr8, ipc8, ipc48, valid8);
    end
  endtask

  task automatic test_random(input int lat, input int ncyc);
    logic [31:0] exp_pc, h_pc, h_pc4, h_i;
    logic        prev_redir, hold;
    int          consumed;
    lat_mode = lat;
    do_reset();
    exp_pc = 32'h0; prev_redir = 1'b0; hold = 1'b0; consumed = 0;
    h_pc = 32'h0; h_pc4 = 32'h0; h_i = 32'h0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (prev_redir) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_flush lat=%0d cyc=%0d got v=%0b exp 0", lat, i, instr_valid);
        end
      end else if (hold) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== h_pc || instr_pc4 !== h_pc4 || instr !== h_i) begin
          errors++;
          $display("FAIL rnd_hold lat=%0d cyc=%0d got v=%0b pc=%h exp pc=%h", lat, i,
                   instr_valid, instr_pc, h_pc);
        end
      end
      stall = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect_sel = 2'($urandom_range(1, 3));
        redirect_pc4 = $urandom & 32'hFFFF_FFFC;
        sign_imm     = 32'($urandom_range(0, 63)) - 32'd32;
        jump_idx     = 26'($urandom);
        reg_target   = $urandom;
      end else begin
        redirect_sel = 2'd0;
      end
      #1;
      if (instr_valid && !stall) begin
        checks++;
        if (instr_pc !== exp_pc || instr_pc4 !== exp_pc + 32'd4 || instr !== memf(exp_pc)) begin
          errors++;
          $display("FAIL rnd_stream lat=%0d cyc=%0d got pc=%h pc4=%h instr=%h exp pc=%h instr=%h",
                   lat, i, instr_pc, instr_pc4, instr, exp_pc, memf(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      hold  = instr_valid && stall && (redirect_sel == 2'd0);
      h_pc  = instr_pc; h_pc4 = instr_pc4; h_i = instr;
      prev_redir = (redirect_sel != 2'd0);
      if (prev_redir) exp_pc = model_target(redirect_sel, redirect_pc4, sign_imm, jump_idx, reg_target);
    end
    checks++;
    if (consumed < ncyc / 10) begin
      errors++;
      $display("FAIL rnd_progress lat=%0d got %0d exp at least %0d", lat, consumed, ncyc / 10);
    end
    stall = 1'b0; redirect_sel = 2'd0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_sel = 2'd0; redirect_pc4 = 32'h0; sign_imm = 32'h0;
    jump_idx = 26'h0; reg_target = 32'h0; r8_sel = 2'd0; r8_tgt = 8'h0;
    lat_mode = 0; ovr_ack = 1'b0; ovr_data = 32'h0; paddr = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_drain();
    test_misalign();
    test_wrap();
    test_random(0, 300);
    test_random(2, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
